// File: rtl/evr_dc_pkg.sv
// evr_dc_pkg: shared types and FIFO timing constants for the delay-compensation
// read-clock datapath.
package evr_dc_pkg;

  localparam int DC_WORD_WIDTH       = 32;
  localparam int DC_FIFO_RD_LATENCY  = 2;
  localparam int DC_FIFO_RST_HOLDOFF = 5;

  typedef logic [DC_WORD_WIDTH-1:0] dc_word_t;

  // Number of set bits; used to count reads still travelling through the FIFO.
  function automatic int unsigned bit_count(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_ring_buf.sv
// sync_ring_buf: small circular landing buffer with a registered-array head
// read. Push and pop in the same cycle leave the occupancy unchanged.
module sync_ring_buf
  import evr_dc_pkg::*;
#(
  parameter int WIDTH = DC_WORD_WIDTH,
  parameter int DEPTH = DC_FIFO_RD_LATENCY + 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop & (count_q != '0);
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Buffer state registers; reset empties the buffer and zeroes the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side controller for the dual-clock FIFO. Issues reads
// only when the landing buffer is guaranteed room for the word, so the FIFO's
// fixed read latency is hidden behind a lossless valid/ready stream.
module fifo_rd_stream
  import evr_dc_pkg::*;
#(
  parameter int WIDTH       = DC_WORD_WIDTH,
  parameter int RD_LATENCY  = DC_FIFO_RD_LATENCY,
  parameter int RST_HOLDOFF = DC_FIFO_RST_HOLDOFF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_d_out,
  input  logic             fifo_empty,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      rd_count
);

  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int HOLD_W    = (RST_HOLDOFF < 1) ? 1 : $clog2(RST_HOLDOFF + 1);

  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic [CNT_W-1:0]      buf_count;
  logic [7:0]            occ;
  logic                  done, pop, push;

  assign done     = (hold_q == '0);
  assign push     = pipe_q[RD_LATENCY-1];
  assign m_valid  = (buf_count != '0);
  assign pop      = m_valid & m_ready;
  assign rd_count = rd_count_q;

  // Issue a read only when its word is certain to find a free landing slot.
  always_comb begin
    occ        = 8'(bit_count(32'(pipe_q))) + 8'(buf_count) - 8'(pop);
    fifo_rd_en = ~rst & done & ~fifo_empty & (occ < 8'(BUF_DEPTH));
  end

  // Next-state for holdoff down-counter, in-flight pipe and delivered-word count.
  always_comb begin
    hold_d = hold_q;
    if (!done) begin
      hold_d = hold_q - 1'b1;
    end
    pipe_d     = pipe_q << 1;
    pipe_d[0]  = fifo_rd_en;
    rd_count_d = rd_count_q + 16'(pop);
  end

  // Control registers; reset drops every in-flight read and restarts holdoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= HOLD_W'(RST_HOLDOFF);
      pipe_q     <= '0;
      rd_count_q <= '0;
    end else begin
      hold_q     <= hold_d;
      pipe_q     <= pipe_d;
      rd_count_q <= rd_count_d;
    end
  end

  sync_ring_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_land (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_d_out),
    .pop       (pop),
    .count     (buf_count),
    .head      (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench for fifo_rd_stream with a latency-2 FIFO
// model whose word at absolute read index k is k+1.
module tb_fifo_rd_stream;
  import evr_dc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rd_en;
  dc_word_t    fifo_d_out;
  logic        fifo_empty;
  dc_word_t    m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] rd_count;

  int unsigned pushed_n = 0;
  int unsigned popped_n = 0;
  logic        empty_force = 1'b0;
  dc_word_t    s1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_idx = 0;
  int unsigned delivered = 0;
  int unsigned issued = 0;
  logic        prev_hold = 1'b0;
  dc_word_t    prev_data = '0;

  logic        s_rd_en, s_valid;
  dc_word_t    s_data;
  logic [15:0] s_cnt;

  always #5 clk = ~clk;

  assign fifo_empty = (pushed_n == popped_n) || empty_force;

  fifo_rd_stream dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (fifo_rd_en),
    .fifo_d_out (fifo_d_out),
    .fifo_empty (fifo_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .rd_count   (rd_count)
  );

  // FIFO read port model: two-clock read latency, garbage when not reading.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= 32'hDEAD_BEEF;
      fifo_d_out <= 32'hDEAD_BEEF;
      popped_n   <= pushed_n;
    end else begin
      s1         <= fifo_rd_en ? dc_word_t'(popped_n + 1) : 32'hDEAD_BEEF;
      fifo_d_out <= s1;
      if (fifo_rd_en && (pushed_n != popped_n)) popped_n <= popped_n + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, delivered=%0d", delivered);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: called just after an edge, returns on the next edge.
  task automatic cycle(input logic rdy, input logic ef, input int unsigned npush);
    logic pop_now;
    #1;
    m_ready     = rdy;
    empty_force = ef;
    pushed_n    = pushed_n + npush;
    #1;
    s_rd_en = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_cnt   = rd_count;
    chk("rd_count", 32'(s_cnt), 32'(16'(delivered)));
    if (prev_hold) begin
      chk("hold_valid", 32'(s_valid), 32'd1);
      chk("hold_data", s_data, prev_data);
    end
    if (s_rd_en) chk("rd_when_empty", 32'(fifo_empty), 32'd0);
    pop_now = s_valid && rdy;
    if (pop_now) begin
      chk("data", s_data, dc_word_t'(exp_idx + 1));
      exp_idx++;
      delivered++;
    end
    if (s_rd_en) begin
      issued++;
      chk("outstanding_le3", 32'((issued - delivered) <= 3), 32'd1);
    end
    prev_hold = s_valid && !rdy;
    prev_data = s_data;
    @(posedge clk);
  endtask

  // Called one time unit after an edge; returns one unit after a later edge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_count", 32'(rd_count), 32'd0);
    chk("rst_data", m_data, 32'd0);
    exp_idx   = pushed_n;
    delivered = 0;
    issued    = 0;
    prev_hold = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Holdoff: five clocks of no read with the FIFO full, then a read.
    cycle(1'b1, 1'b0, 64);
    chk("holdoff_low", 32'(s_rd_en), 32'd0);
    for (int i = 1; i < 5; i++) begin
      cycle(1'b1, 1'b0, 0);
      chk("holdoff_low", 32'(s_rd_en), 32'd0);
    end
    cycle(1'b1, 1'b0, 0);
    chk("holdoff_rise", 32'(s_rd_en), 32'd1);
    chk("start_lat0", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 0);
    chk("start_lat1", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 0);
    chk("start_lat2", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 0);
    chk("start_lat3", 32'(s_valid), 32'd1);
    chk("first_word", s_data, 32'h1);

    // Streaming: one word per clock until 0x40 words are out.
    n = 0;
    while (delivered < 64 && n < 200) begin
      cycle(1'b1, 1'b0, 0);
      chk("stream_cont", 32'(s_valid), 32'd1);
      n++;
    end
    chk("stream_total", delivered, 32'd64);
    cycle(1'b1, 1'b0, 0);
    chk("stream_count", 32'(s_cnt), 32'h40);
    chk("stream_drained", 32'(s_valid), 32'd0);

    // Backpressure: ready low for cycles 10..30.
    for (int i = 0; i < 60; i++) begin
      cycle(!(i >= 10 && i <= 30), 1'b0, (i == 0) ? 40 : 0);
      if (i == 30) begin
        chk("bp_outstanding", issued - delivered, 32'd3);
        chk("bp_valid", 32'(s_valid), 32'd1);
      end
    end
    n = 0;
    while (delivered < 104 && n < 100) begin
      cycle(1'b1, 1'b0, 0);
      n++;
    end
    chk("bp_total", delivered, 32'd104);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    chk("bp_drained", 32'(s_valid), 32'd0);

    // Mid-stream reset with two reads in flight and one word buffered.
    cycle(1'b0, 1'b0, 5);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    #1;
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    chk("pre_rst_outstanding", issued - delivered, 32'd3);
    do_reset();
    pushed_n = pushed_n + 8;
    n = 0;
    s_valid = 1'b0;
    while (!s_valid && n < 20) begin
      cycle(1'b1, 1'b0, 0);
      n++;
    end
    chk("resume_valid", 32'(s_valid), 32'd1);
    chk("resume_first", s_data, 32'd110);
    n = 0;
    while (delivered < 8 && n < 40) begin
      cycle(1'b1, 1'b0, 0);
      n++;
    end
    chk("resume_total", delivered, 32'd8);

    // Random ready, supply and empty flag.
    n = 0;
    while (delivered < 1508 && n < 20000) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, $urandom_range(0, 1));
      n++;
    end
    chk("rand_total", delivered, 32'd1508);

    // Run on to 65537 words since reset so the counter wraps to 1.
    n = 0;
    while (delivered < 65537 && n < 70000) begin
      cycle(1'b1, 1'b0, 1);
      n++;
    end
    chk("wrap_total", delivered, 32'd65537);
    cycle(1'b0, 1'b0, 0);
    chk("wrap_count", 32'(s_cnt), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
